// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STRB_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic   req_inst_i,
  input  logic   req_data_i,
  input  owner_e last_grant_i,
  output logic   gnt_inst_o,
  output logic   gnt_data_o
);

  always_comb begin
    gnt_inst_o = 1'b0;
    gnt_data_o = 1'b0;
    if (req_inst_i && req_data_i) begin
      if (last_grant_i == OWN_INST) gnt_data_o = 1'b1;
      else                          gnt_inst_o = 1'b1;
    end else begin
      gnt_inst_o = req_inst_i;
      gnt_data_o = req_data_i;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned STRB_W = STRB_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q,  last_d;
  logic                wr_q,    wr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                gnt_inst, gnt_data;

  arb_rr2 u_arb (
    .req_inst_i   (inst_req),
    .req_data_i   (data_req),
    .last_grant_i (last_q),
    .gnt_inst_o   (gnt_inst),
    .gnt_data_o   (gnt_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= OWN_INST;
      last_q  <= OWN_INST;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_data) begin
          state_d = REQ;
          owner_d = OWN_DATA;
          last_d  = OWN_DATA;
          wr_d    = data_wr;
          wstrb_d = data_wstrb;
          addr_d  = data_addr;
          wdata_d = data_wdata;
        end else if (gnt_inst) begin
          state_d = REQ;
          owner_d = OWN_INST;
          last_d  = OWN_INST;
          wr_d    = 1'b0;
          wstrb_d = '0;
          addr_d  = inst_addr;
          wdata_d = '0;
        end
      end
      REQ:     if (mem_addr_ok) state_d = WAIT;
      WAIT:    if (mem_data_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshakes route to the latched owner only, never to whoever is requesting now.
  assign mem_req      = (state_q == REQ);
  assign mem_wr       = wr_q;
  assign mem_wstrb    = wstrb_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;

  assign inst_addr_ok = (state_q == REQ)  && (owner_q == OWN_INST) && mem_addr_ok;
  assign data_addr_ok = (state_q == REQ)  && (owner_q == OWN_DATA) && mem_addr_ok;
  assign inst_data_ok = (state_q == WAIT) && (owner_q == OWN_INST) && mem_data_ok;
  assign data_data_ok = (state_q == WAIT) && (owner_q == OWN_DATA) && mem_data_ok;

  assign inst_rdata   = resetn ? mem_rdata : '0;
  assign data_rdata   = resetn ? mem_rdata : '0;

endmodule
